alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 188 ++++++++++++++++++
 tb/tb_alu_md.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
`default_nettype none
// alu_md: single-issue integer ALU with an iterative shift-add multiplier and a restoring divider.
// Revision 1.0 -- initial release
module alu_md #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mext,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_slt
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] opa, acc, lo;
  logic            neg_q, neg_r, sel_alt;
  logic            last;

  logic [SHW-1:0]  shamt;
  logic            lt;
  logic [XLEN-1:0] base_res;

  logic            is_div, sgn1, sgn2, neg1, neg2;
  logic            div_zero, div_ovf, div_bypass;
  logic [XLEN-1:0] mag1, mag2, bypass_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod, mul_fin;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   div_rem, div_quo, quo_fin, rem_fin;

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign shamt   = i_op2[SHW-1:0];
  assign last    = (cnt == CW'(XLEN - 1));

  // Base ALU, evaluated on live inputs and captured only at acceptance
  always_comb begin
    lt       = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
    base_res = '0;
    case (i_opsel)
      3'b000: base_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      3'b001: base_res = i_op1 << shamt;
      3'b010,
      3'b011: base_res = {{(XLEN-1){1'b0}}, lt};
      3'b100: base_res = i_op1 ^ i_op2;
      3'b101: begin
        if (i_arith) base_res = $signed(i_op1) >>> shamt;
        else         base_res = i_op1 >> shamt;
      end
      3'b110: base_res = i_op1 | i_op2;
      default: base_res = i_op1 & i_op2;
    endcase
  end

  // Signed M ops run on magnitudes; the sign is reapplied on the final step
  always_comb begin
    is_div     = i_opsel[2];
    sgn1       = is_div ? ~i_opsel[0] : (i_opsel[1:0] == 2'b01 || i_opsel[1:0] == 2'b10);
    sgn2       = is_div ? ~i_opsel[0] : (i_opsel[1:0] == 2'b01);
    neg1       = sgn1 & i_op1[XLEN-1];
    neg2       = sgn2 & i_op2[XLEN-1];
    mag1       = neg1 ? -i_op1 : i_op1;
    mag2       = neg2 ? -i_op2 : i_op2;
    div_zero   = (i_op2 == '0);
    div_ovf    = ~i_opsel[0] && (i_op1 == MIN_NEG) && (i_op2 == '1);
    div_bypass = is_div && (div_zero || div_ovf);
    if (div_zero) bypass_res = i_opsel[1] ? i_op1 : '1;
    else          bypass_res = i_opsel[1] ? '0 : i_op1;
  end

  assign mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
  assign mul_prod = {mul_sum, lo[XLEN-1:1]};
  assign mul_fin  = neg_q ? -mul_prod : mul_prod;

  assign rem_sh   = {acc, lo[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opa};
  assign div_rem  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
  assign div_quo  = {lo[XLEN-2:0], ~rem_diff[XLEN]};
  assign quo_fin  = neg_q ? -div_quo : div_quo;
  assign rem_fin  = neg_r ? -div_rem : div_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (!i_mext || div_bypass) state_nx = DONE;
          else if (i_opsel[2])       state_nx = DIV;
          else                       state_nx = MUL;
        end
      end
      MUL, DIV: if (last) state_nx = DONE;
      DONE:     if (i_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_eq     <= 1'b0;
      o_slt    <= 1'b0;
      cnt      <= '0;
      opa      <= '0;
      acc      <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_alt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            cnt <= '0;
            acc <= '0;
            if (!i_mext) begin
              o_result <= base_res;
              o_eq     <= (i_op1 == i_op2);
              o_slt    <= lt;
            end else begin
              o_eq    <= 1'b0;
              o_slt   <= 1'b0;
              sel_alt <= is_div ? i_opsel[1] : (i_opsel[1:0] != 2'b00);
              neg_q   <= neg1 ^ neg2;
              neg_r   <= neg1;
              if (div_bypass) begin
                o_result <= bypass_res;
              end else if (is_div) begin
                opa <= mag2;
                lo  <= mag1;
              end else begin
                opa <= mag1;
                lo  <= mag2;
              end
            end
          end
        end
        MUL: begin
          cnt <= cnt + CW'(1);
          if (last) o_result <= sel_alt ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
          else      {acc, lo} <= mul_prod;
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            o_result <= sel_alt ? rem_fin : quo_fin;
          end else begin
            acc <= div_rem;
            lo  <= div_quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// tb_alu_md: directed vector table for alu_md (XLEN=32) plus handshake, reset and XLEN=8 sequences.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, rdy = 1'b0;
  logic        mext = 1'b0, sub = 1'b0, uns = 1'b0, ari = 1'b0;
  logic [2:0]  opsel = 3'd0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        o_ready, o_valid, o_eq, o_slt;
  logic [31:0] o_result;

  logic        valid8 = 1'b0, rdy8 = 1'b0, mext8 = 1'b0;
  logic [2:0]  opsel8 = 3'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, ovalid8, eq8, slt8;
  logic [7:0]  res8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_md #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_mext(mext), .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns), .i_arith(ari),
    .i_op1(op1), .i_op2(op2), .o_valid(o_valid), .i_ready(rdy),
    .o_result(o_result), .o_eq(o_eq), .o_slt(o_slt)
  );

  alu_md #(.XLEN(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid8), .o_ready(ready8),
    .i_mext(mext8), .i_opsel(opsel8), .i_sub(1'b0), .i_unsigned(1'b0), .i_arith(1'b0),
    .i_op1(a8), .i_op2(b8), .o_valid(ovalid8), .i_ready(rdy8),
    .o_result(res8), .o_eq(eq8), .o_slt(slt8)
  );

  typedef struct {
    logic        mext;
    logic [2:0]  sel;
    logic        sub, uns, ari;
    logic [31:0] a, b, res;
    logic        eq, slt;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic m, input logic [2:0] s, input logic su, input logic un,
                              input logic ar, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic e, input logic lt, input int l);
    vec_t v;
    v.mext = m; v.sel = s; v.sub = su; v.uns = un; v.ari = ar;
    v.a = a; v.b = b; v.res = r; v.eq = e; v.slt = lt; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), 64'(o_ready), 64'd1);
    mext = t.mext; opsel = t.sel; sub = t.sub; uns = t.uns; ari = t.ari;
    op1 = t.a; op2 = t.b; valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the result must come from latched values
    valid = 1'b0; op1 = ~op1; op2 = op2 ^ 32'h5A5A_A5A5; opsel = ~opsel;
    mext = ~mext; sub = ~sub; uns = ~uns; ari = ~ari;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d result", idx), 64'(o_result), 64'(t.res));
    chk($sformatf("v%0d eq", idx), 64'(o_eq), 64'(t.eq));
    chk($sformatf("v%0d slt", idx), 64'(o_slt), 64'(t.slt));
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(t.lat));
    @(negedge clk); rdy = 1'b1;
    @(posedge clk); #1; rdy = 1'b0;
    chk($sformatf("v%0d consumed", idx), 64'({o_valid, o_ready}), 64'b01);
  endtask

  initial begin
    int lat;
    int stale;
    // Base ops
    vecs.push_back(mk(0, 3'b000, 1, 0, 0, 32'd5,         32'd7,         32'hFFFF_FFFE, 0, 1, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0, 0, 1));
    vecs.push_back(mk(0, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 1, 1));
    vecs.push_back(mk(0, 3'b101, 0, 0, 0, 32'h8000_0000, 32'd4,         32'h0800_0000, 0, 1, 1));
    vecs.push_back(mk(0, 3'b101, 0, 0, 1, 32'h8000_0000, 32'h20,        32'h8000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 3'b001, 0, 0, 0, 32'd1,         32'h21,        32'd2,         0, 1, 1));
    vecs.push_back(mk(0, 3'b011, 0, 1, 0, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 0, 1));
    vecs.push_back(mk(0, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 32'd1,         32'd1,         0, 1, 1));
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1, 1));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1, 0, 1));
    vecs.push_back(mk(0, 3'b110, 0, 0, 0, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h0FFF_0FFF, 0, 1, 1));
    // Multiply
    vecs.push_back(mk(1, 3'b000, 1, 1, 1, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 0, 0, 33));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 0, 0, 33));
    vecs.push_back(mk(1, 3'b001, 0, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 33));
    vecs.push_back(mk(1, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33));
    vecs.push_back(mk(1, 3'b011, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 33));
    vecs.push_back(mk(1, 3'b001, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         0, 0, 33));
    // Divide / remainder
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0, 33));
    vecs.push_back(mk(1, 3'b110, 0, 0, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 0, 33));
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 33));
    vecs.push_back(mk(1, 3'b110, 0, 0, 0, 32'd7,         32'hFFFF_FFFE, 32'd1,         0, 0, 33));
    vecs.push_back(mk(1, 3'b101, 0, 0, 0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 0, 0, 33));
    vecs.push_back(mk(1, 3'b111, 0, 0, 0, 32'hFFFF_FFFF, 32'd2,         32'd1,         0, 0, 33));
    vecs.push_back(mk(1, 3'b101, 0, 0, 0, 32'd7,         32'd0,         32'hFFFF_FFFF, 0, 0, 1));
    vecs.push_back(mk(1, 3'b111, 0, 0, 0, 32'd7,         32'd0,         32'd7,         0, 0, 1));
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 0, 0, 1));
    vecs.push_back(mk(1, 3'b110, 0, 0, 0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0, 0, 1));
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1));
    vecs.push_back(mk(1, 3'b110, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 0, 1));
    vecs.push_back(mk(1, 3'b101, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 0, 33));
    vecs.push_back(mk(1, 3'b111, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 33));

    // Reset state, with inputs active to show they are ignored
    valid = 1'b1; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 64'({o_valid, o_eq, o_slt}), 64'd0);
    chk("reset result", 64'(o_result), 64'd0);
    chk("reset ready", 64'(o_ready), 64'd1);
    @(negedge clk); valid = 1'b0; rdy = 1'b0; rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Result held while consumer stalls; requests during the stall are dropped
    @(negedge clk);
    mext = 1'b0; opsel = 3'b000; sub = 1'b0; op1 = 32'd1; op2 = 32'd2; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hold first valid", 64'(lat), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); valid = 1'b1; op1 = 32'd99 + 32'(c); op2 = 32'd99 + 32'(c);
      @(posedge clk); #1;
      chk($sformatf("hold c%0d", c), 64'({o_valid, o_ready, o_eq, o_slt, o_result}), {28'd0, 4'b1001, 32'd3});
    end
    @(negedge clk); valid = 1'b0; rdy = 1'b1;
    @(posedge clk); #1; rdy = 1'b0;
    chk("hold released", 64'({o_valid, o_ready}), 64'b01);
    apply(vecs[0], 100);

    // Reset during a DIVU iteration aborts it
    @(negedge clk);
    mext = 1'b1; opsel = 3'b101; op1 = 32'd100; op2 = 32'd7; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("abort outputs", 64'({o_valid, o_eq, o_slt}), 64'd0);
    chk("abort result", 64'(o_result), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("abort ready", 64'({o_valid, o_ready}), 64'b01);
    stale = 0;
    repeat (40) begin @(posedge clk); #1; if (o_valid || !o_ready) stale++; end
    chk("abort no stale result", 64'(stale), 64'd0);
    apply(vecs[17], 101);

    // XLEN=8 instance: MULHU latency and shamt truncation
    @(negedge clk);
    mext8 = 1'b1; opsel8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF; valid8 = 1'b1;
    @(posedge clk); #1; valid8 = 1'b0; a8 = 8'h00;
    lat = 1;
    while (!ovalid8 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("x8 mulhu result", 64'(res8), 64'hFE);
    chk("x8 mulhu latency", 64'(lat), 64'd9);
    @(negedge clk); rdy8 = 1'b1;
    @(posedge clk); #1; rdy8 = 1'b0;
    @(negedge clk);
    mext8 = 1'b0; opsel8 = 3'b001; a8 = 8'h01; b8 = 8'h0B; valid8 = 1'b1;
    @(posedge clk); #1; valid8 = 1'b0;
    chk("x8 sll", 64'({ovalid8, eq8, slt8, res8}), {53'd0, 3'b101, 8'h08});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
